// File: rtl/serdes_tx_8b10b.sv
// ---------------------------------------------------------------------------
// serdes_tx_8b10b
//
// Transmit stage of the SERDES link. Takes bytes over a valid/ready
// handshake, encodes each one to a 10-bit 8b/10b symbol against the current
// running disparity, and shifts the symbol out one bit per clock, MSB
// (bit 'a') first. K28.5 commas are inserted for receiver alignment: a burst
// of SYNC_COMMAS after reset, whenever no byte is offered at a word boundary,
// and one forced comma after every COMMA_PERIOD consecutive data words.
//
// Parameters
//   SYNC_COMMAS   K28.5 words sent after reset before data is taken (1..15)
//   COMMA_PERIOD  max consecutive data words before a forced K28.5 (1..255)
//
// Ports
//   clk        in   bit clock, one serial bit per rising edge
//   resetN     in   asynchronous active-low reset
//   dataIn     in   [7:0] byte to send, HGF = [7:5], EDCBA = [4:0]
//   dataValid  in   dataIn holds a byte to send
//   dataReady  out  byte is taken at this edge if dataValid is high
//   SerialOut  out  serial line to the receiver
//   wordStart  out  high while bit 'a' of a word is on SerialOut
//   commaSent  out  high for all 10 cycles of a K28.5 word
//   RDout      out  running disparity the next word is encoded against
//                   (1 = RD+, 0 = RD-)
// ---------------------------------------------------------------------------
module serdes_tx_8b10b #(
    parameter int SYNC_COMMAS  = 4,
    parameter int COMMA_PERIOD = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] dataIn,
    input  logic       dataValid,
    output logic       dataReady,
    output logic       SerialOut,
    output logic       wordStart,
    output logic       commaSent,
    output logic       RDout
);

    localparam logic [3:0]  SYNC_N   = 4'(SYNC_COMMAS);
    localparam logic [7:0]  PERIOD_N = 8'(COMMA_PERIOD);
    localparam logic [3:0]  LAST_BIT = 4'd9;

    // K28.5 in both disparities; word order {a,b,c,d,e,i,f,g,h,j}
    localparam logic [9:0]  K285_NEG = 10'b0011111010;
    localparam logic [9:0]  K285_POS = 10'b1100000101;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Code tables, RD- column only. The RD+ form of every unbalanced
    // sub-block is its complement; the two balanced exceptions (D.7 111000,
    // D.x.3 1100) are complemented too, which is handled by the caller.
    // -----------------------------------------------------------------------
    function automatic logic [5:0] enc6(input logic [4:0] x);
        logic [5:0] r;
        r = 6'b000000;
        case (x)
            5'd0:  r = 6'b100111;
            5'd1:  r = 6'b011101;
            5'd2:  r = 6'b101101;
            5'd3:  r = 6'b110001;
            5'd4:  r = 6'b110101;
            5'd5:  r = 6'b101001;
            5'd6:  r = 6'b011001;
            5'd7:  r = 6'b111000;
            5'd8:  r = 6'b111001;
            5'd9:  r = 6'b100101;
            5'd10: r = 6'b010101;
            5'd11: r = 6'b110100;
            5'd12: r = 6'b001101;
            5'd13: r = 6'b101100;
            5'd14: r = 6'b011100;
            5'd15: r = 6'b010111;
            5'd16: r = 6'b011011;
            5'd17: r = 6'b100011;
            5'd18: r = 6'b010011;
            5'd19: r = 6'b110010;
            5'd20: r = 6'b001011;
            5'd21: r = 6'b101010;
            5'd22: r = 6'b011010;
            5'd23: r = 6'b111010;
            5'd24: r = 6'b110011;
            5'd25: r = 6'b100110;
            5'd26: r = 6'b010110;
            5'd27: r = 6'b110110;
            5'd28: r = 6'b001110;
            5'd29: r = 6'b101110;
            5'd30: r = 6'b011110;
            5'd31: r = 6'b101011;
            default: r = 6'b000000;
        endcase
        return r;
    endfunction

    // D.x.y for y = 0..6 plus both forms of y = 7 (P7 / A7)
    function automatic logic [3:0] enc4(input logic [2:0] y, input logic alt7);
        logic [3:0] r;
        r = 4'b0000;
        case (y)
            3'd0: r = 4'b1011;
            3'd1: r = 4'b1001;
            3'd2: r = 4'b0101;
            3'd3: r = 4'b1100;
            3'd4: r = 4'b1101;
            3'd5: r = 4'b1010;
            3'd6: r = 4'b0110;
            3'd7: r = alt7 ? 4'b0111 : 4'b1110;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [9:0] shreg_q,   shreg_d;
    logic [3:0] bitcnt_q,  bitcnt_d;
    logic       rd_q,      rd_d;
    state_t     state_q,   state_d;
    logic [3:0] synccnt_q, synccnt_d;
    logic [7:0] datacnt_q, datacnt_d;
    logic       comma_q,   comma_d;

    // -----------------------------------------------------------------------
    // Data encoder: combinational, always encoding dataIn against rd_q
    // -----------------------------------------------------------------------
    logic [4:0] x5;
    logic [2:0] y3;
    logic [5:0] raw6, code6;
    logic [3:0] raw4, code4;
    logic       bal6, bal4, rd6, rd_word, alt7;
    logic [9:0] data_word;

    always_comb begin
        x5   = dataIn[4:0];
        y3   = dataIn[7:5];

        raw6 = enc6(x5);
        bal6 = ($countones(raw6) == 3);
        // D.7 is balanced but still has distinct RD-/RD+ forms
        code6 = (rd_q && (!bal6 || x5 == 5'd7)) ? ~raw6 : raw6;
        rd6   = bal6 ? rd_q : ~rd_q;

        // A7 avoids a run of five equal bits across the e/i-f boundary
        alt7 = (y3 == 3'd7) &&
               ((!rd6 && (x5 == 5'd17 || x5 == 5'd18 || x5 == 5'd20)) ||
                ( rd6 && (x5 == 5'd11 || x5 == 5'd13 || x5 == 5'd14)));

        raw4  = enc4(y3, alt7);
        bal4  = ($countones(raw4) == 2);
        // D.x.3 is balanced but still has distinct RD-/RD+ forms
        code4 = (rd6 && (!bal4 || y3 == 3'd3)) ? ~raw4 : raw4;
        rd_word = bal4 ? rd6 : ~rd6;

        data_word = {code6, code4};
    end

    // -----------------------------------------------------------------------
    // Control FSM: next state and outputs
    // -----------------------------------------------------------------------
    logic       load;
    logic       accept;
    logic [9:0] k_word;

    always_comb begin
        load      = (bitcnt_q == LAST_BIT);
        k_word    = rd_q ? K285_POS : K285_NEG;
        dataReady = (state_q == ST_DATA) && load && (datacnt_q < PERIOD_N);
        accept    = dataReady && dataValid;

        shreg_d   = {shreg_q[8:0], 1'b0};
        bitcnt_d  = bitcnt_q + 4'd1;
        rd_d      = rd_q;
        state_d   = state_q;
        synccnt_d = synccnt_q;
        datacnt_d = datacnt_q;
        comma_d   = comma_q;

        if (load) begin
            bitcnt_d = 4'd0;
            case (state_q)
                ST_SYNC: begin
                    shreg_d   = k_word;
                    rd_d      = ~rd_q;
                    comma_d   = 1'b1;
                    synccnt_d = synccnt_q + 4'd1;
                    if (synccnt_q + 4'd1 == SYNC_N) begin
                        state_d   = ST_DATA;
                        datacnt_d = 8'd0;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        shreg_d   = data_word;
                        rd_d      = rd_word;
                        comma_d   = 1'b0;
                        datacnt_d = datacnt_q + 8'd1;
                    end else begin
                        // idle or forced comma; a pending byte waits
                        shreg_d   = k_word;
                        rd_d      = ~rd_q;
                        comma_d   = 1'b1;
                        datacnt_d = 8'd0;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers. bitcnt resets to 9 so the first edge after release loads
    // a word; rd resets to RD+ so that word is the K28.5 the receiver
    // locks onto.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shreg_q   <= 10'd0;
            bitcnt_q  <= LAST_BIT;
            rd_q      <= 1'b1;
            state_q   <= ST_SYNC;
            synccnt_q <= 4'd0;
            datacnt_q <= 8'd0;
            comma_q   <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            rd_q      <= rd_d;
            state_q   <= state_d;
            synccnt_q <= synccnt_d;
            datacnt_q <= datacnt_d;
            comma_q   <= comma_d;
        end
    end

    assign SerialOut = shreg_q[9];
    assign wordStart = (bitcnt_q == 4'd0);
    assign commaSent = comma_q;
    assign RDout     = rd_q;

endmodule

// File: tb/tb_serdes_tx_8b10b.sv
// ---------------------------------------------------------------------------
// tb_serdes_tx_8b10b
//
// Directed bench. dut uses default parameters; dut2 uses COMMA_PERIOD=2 for
// the back-to-back forced-comma case. Both share clock and reset. Inputs
// change and outputs are sampled on the falling edge. Each word step starts
// at the falling edge where the DUT is showing bit j (next edge loads).
// ---------------------------------------------------------------------------
module tb_serdes_tx_8b10b;

    logic       clk;
    logic       resetN;
    logic [7:0] dataIn,    dataIn2;
    logic       dataValid, dataValid2;
    logic       dataReady, dataReady2;
    logic       SerialOut, SerialOut2;
    logic       wordStart, wordStart2;
    logic       commaSent, commaSent2;
    logic       RDout,     RDout2;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [9:0] KP = 10'b1100000101;
    localparam logic [9:0] KN = 10'b0011111010;

    serdes_tx_8b10b dut (
        .clk(clk), .resetN(resetN), .dataIn(dataIn), .dataValid(dataValid),
        .dataReady(dataReady), .SerialOut(SerialOut), .wordStart(wordStart),
        .commaSent(commaSent), .RDout(RDout)
    );

    serdes_tx_8b10b #(.SYNC_COMMAS(4), .COMMA_PERIOD(2)) dut2 (
        .clk(clk), .resetN(resetN), .dataIn(dataIn2), .dataValid(dataValid2),
        .dataReady(dataReady2), .SerialOut(SerialOut2), .wordStart(wordStart2),
        .commaSent(commaSent2), .RDout(RDout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs,
                         input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One 10-bit word on dut. exp_rdy is dataReady over the 10 samples.
    task automatic xfer(input string tag, input logic v, input logic [7:0] d,
                        input logic [9:0] exp_w, input logic exp_cs,
                        input logic [9:0] exp_rdy, input logic exp_rd);
        logic [9:0] w, ws, cs, rdy;
        dataValid = v;
        dataIn    = d;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            dataValid = 1'b0;
            w[i]   = SerialOut;
            ws[i]  = wordStart;
            cs[i]  = commaSent;
            rdy[i] = dataReady;
        end
        check({tag, "/word"},  w,   exp_w);
        check({tag, "/start"}, ws,  10'b1000000000);
        check({tag, "/comma"}, cs,  {10{exp_cs}});
        check({tag, "/ready"}, rdy, exp_rdy);
        check({tag, "/rd"},    {9'd0, RDout}, {9'd0, exp_rd});
    endtask

    // One word on dut2 with dataValid2 held high.
    task automatic xfer2(input string tag, input logic [7:0] d,
                         input logic exp_rdy, input logic [9:0] exp_w,
                         input logic exp_cs, input logic exp_rd);
        logic [9:0] w;
        logic       ws;
        dataValid2 = 1'b1;
        dataIn2    = d;
        check({tag, "/ready"}, {9'd0, dataReady2}, {9'd0, exp_rdy});
        ws = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            w[i] = SerialOut2;
            if (i == 9) ws = wordStart2;
        end
        check({tag, "/word"},  w, exp_w);
        check({tag, "/start"}, {9'd0, ws}, 10'd1);
        check({tag, "/comma"}, {9'd0, commaSent2}, {9'd0, exp_cs});
        check({tag, "/rd"},    {9'd0, RDout2}, {9'd0, exp_rd});
    endtask

    initial begin
        logic [9:0] part;
        resetN = 1'b0; dataIn = 8'h00; dataValid = 1'b0;
        dataIn2 = 8'h00; dataValid2 = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst/serial",  {9'd0, SerialOut}, 10'd0);
        check("rst/ready",   {9'd0, dataReady}, 10'd0);
        check("rst/start",   {9'd0, wordStart}, 10'd0);
        check("rst/rd",      {9'd0, RDout},     10'd1);
        check("rst/comma",   {9'd0, commaSent}, 10'd0);

        // start-up comma burst
        resetN = 1'b1;
        xfer("sync1", 1'b0, 8'h00, KP, 1'b1, 10'd0, 1'b0);
        xfer("sync2", 1'b0, 8'h00, KN, 1'b1, 10'd0, 1'b1);
        xfer("sync3", 1'b0, 8'h00, KP, 1'b1, 10'd0, 1'b0);
        xfer("sync4", 1'b0, 8'h00, KN, 1'b1, 10'd1, 1'b1);

        // idle comma in DATA moves RD to RD-
        xfer("idle",  1'b0, 8'h00, KP, 1'b1, 10'd1, 1'b0);

        // data words
        xfer("d0.0n",  1'b1, 8'h00, 10'b1001110100, 1'b0, 10'd1, 1'b0);
        xfer("d21.5n", 1'b1, 8'hB5, 10'b1010101010, 1'b0, 10'd1, 1'b0);
        xfer("d17.7n", 1'b1, 8'hF1, 10'b1000110111, 1'b0, 10'd1, 1'b1);
        xfer("d21.5p", 1'b1, 8'hB5, 10'b1010101010, 1'b0, 10'd1, 1'b1);
        xfer("d3.3p",  1'b1, 8'h63, 10'b1100010011, 1'b0, 10'd1, 1'b1);
        xfer("d11.7p", 1'b1, 8'hEB, 10'b1101001000, 1'b0, 10'd1, 1'b0);
        xfer("d7.0n",  1'b1, 8'h07, 10'b1110001011, 1'b0, 10'd1, 1'b1);
        xfer("d7.0p",  1'b1, 8'h07, 10'b0001110100, 1'b0, 10'd1, 1'b0);
        xfer("idle2",  1'b0, 8'h00, KN, 1'b1, 10'd1, 1'b1);

        // reset in the middle of a D0.0 (RD+) word, at bitCnt=5
        dataValid = 1'b1; dataIn = 8'h00;
        part = 10'd0;
        for (int i = 9; i >= 4; i--) begin
            @(negedge clk);
            dataValid = 1'b0;
            part[i] = SerialOut;
        end
        check("mid/partial", part, 10'b0110000000);
        resetN = 1'b0;
        #1;
        check("mid/serial", {9'd0, SerialOut}, 10'd0);
        check("mid/rd",     {9'd0, RDout},     10'd1);
        check("mid/start",  {9'd0, wordStart}, 10'd0);
        check("mid/comma",  {9'd0, commaSent}, 10'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        xfer("resync1", 1'b0, 8'h00, KP, 1'b1, 10'd0, 1'b0);
        xfer("resync2", 1'b0, 8'h00, KN, 1'b1, 10'd0, 1'b1);
        xfer("resync3", 1'b0, 8'h00, KP, 1'b1, 10'd0, 1'b0);
        xfer("resync4", 1'b0, 8'h00, KN, 1'b1, 10'd1, 1'b1);

        // COMMA_PERIOD=2, valid held: data, data, forced K28.5, data
        xfer2("cp.d0", 8'h00, 1'b1, 10'b0110001011, 1'b0, 1'b1);
        xfer2("cp.d1", 8'h01, 1'b1, 10'b1000101011, 1'b0, 1'b1);
        xfer2("cp.k",  8'h02, 1'b0, KP,             1'b1, 1'b0);
        xfer2("cp.d2", 8'h02, 1'b1, 10'b1011010100, 1'b0, 1'b0);
        dataValid2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
